// File: rtl/mac_acumulador_if.sv
// Handshake bundle between the multiplier-side source and mac_acumulador.
// The product source and result consumer use the master modport.
// The accumulator uses the slave modport.
interface mac_acumulador_if #(
  parameter int N = 25
);
  logic                  start;
  logic signed [2*N-1:0] prod;
  logic                  prod_valid;
  logic                  prod_ready;
  logic signed [N-1:0]   y;
  logic                  y_valid;
  logic                  ovf;
  logic                  busy;

  modport master (
    output start,
    output prod,
    output prod_valid,
    input  prod_ready,
    input  y,
    input  y_valid,
    input  ovf,
    input  busy
  );

  modport slave (
    input  start,
    input  prod,
    input  prod_valid,
    output prod_ready,
    output y,
    output y_valid,
    output ovf,
    output busy
  );
endinterface

// File: rtl/mac_acumulador.sv
// mac_acumulador: sums M signed 2N-bit products (2F fractional bits), then
// rounds half-up back to F fractional bits and saturates to an N-bit word.
// The FSM moves IDLE -> ACC -> OUT -> IDLE, and OUT lasts one cycle.
// All outputs are registered. The async active-low reset clears everything
// immediately.
module mac_acumulador #(
  parameter int N = 25,
  parameter int F = 15,
  parameter int M = 5
) (
  input  logic            clk,
  input  logic            reset,
  mac_acumulador_if.slave bus
);

  // The accumulator has log2(M) guard bits, so M full-scale products never
  // wrap the sum.
  localparam int ACCW = 2*N + $clog2(M);
  // The rounding adder has one more bit, so adding the half-LSB constant
  // cannot wrap either.
  localparam int RW   = ACCW + 1;
  // The counter is wide enough to reach M itself, which includes the M = 1 case.
  localparam int CW   = $clog2(M + 1);

  localparam logic signed [RW-1:0] RND_HALF = {{(RW-1){1'b0}}, 1'b1} << (F-1);
  localparam logic signed [RW-1:0] Y_MAX    = {{(RW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [RW-1:0] Y_MIN    = {{(RW-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic [CW-1:0]        LAST_IDX = CW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                 state_r;
  logic signed [ACCW-1:0] acc_r;
  logic [CW-1:0]          count_r;
  logic signed [N-1:0]    y_r;
  logic                   y_valid_r;
  logic                   ovf_r;
  logic                   prod_ready_r;
  logic                   busy_r;

  logic signed [ACCW-1:0] acc_next_s;
  logic [N:0]             sat_s;

  // Round half-up to F fractional bits and clamp to the signed N-bit range.
  // The result is packed as {ovf, y}.
  function automatic logic [N:0] round_sat(input logic signed [ACCW-1:0] acc);
    logic signed [RW-1:0] r;
    logic [N:0]           res;
    r = (RW'(acc) + RND_HALF) >>> F;
    if (r > Y_MAX) begin
      res = {1'b1, Y_MAX[N-1:0]};
    end else if (r < Y_MIN) begin
      res = {1'b1, Y_MIN[N-1:0]};
    end else begin
      res = {1'b0, r[N-1:0]};
    end
    return res;
  endfunction

  // Compute the sum that includes the product offered this cycle, and the
  // output word for that sum.
  always_comb begin
    acc_next_s = acc_r + ACCW'(bus.prod);
    sat_s      = round_sat(acc_next_s);
  end

  // Control FSM, accumulator, sample counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      acc_r        <= '0;
      count_r      <= '0;
      y_r          <= '0;
      y_valid_r    <= 1'b0;
      ovf_r        <= 1'b0;
      prod_ready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          y_valid_r <= 1'b0;
          if (bus.start) begin
            acc_r        <= '0;
            count_r      <= '0;
            state_r      <= ACC;
            prod_ready_r <= 1'b1;
            busy_r       <= 1'b1;
          end else begin
            state_r      <= IDLE;
            prod_ready_r <= 1'b0;
            busy_r       <= 1'b0;
          end
        end

        ACC: begin
          y_valid_r <= 1'b0;
          busy_r    <= 1'b1;
          if (bus.prod_valid && prod_ready_r) begin
            acc_r   <= acc_next_s;
            count_r <= count_r + CW'(1);
            if (count_r == LAST_IDX) begin
              // The M-th product closes the sample, and the result is
              // registered on the same edge.
              state_r      <= OUT;
              prod_ready_r <= 1'b0;
              y_valid_r    <= 1'b1;
              y_r          <= sat_s[N-1:0];
              ovf_r        <= sat_s[N];
            end else begin
              state_r      <= ACC;
              prod_ready_r <= 1'b1;
            end
          end else begin
            // Gap cycles leave acc_r and count_r unchanged. There is no timeout.
            state_r      <= ACC;
            prod_ready_r <= 1'b1;
          end
        end

        OUT: begin
          // y_r and ovf_r keep their values until the next OUT.
          state_r      <= IDLE;
          y_valid_r    <= 1'b0;
          prod_ready_r <= 1'b0;
          busy_r       <= 1'b0;
        end

        default: begin
          state_r      <= IDLE;
          acc_r        <= '0;
          count_r      <= '0;
          y_valid_r    <= 1'b0;
          prod_ready_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod_ready = prod_ready_r;
  assign bus.y          = y_r;
  assign bus.y_valid    = y_valid_r;
  assign bus.ovf        = ovf_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_mac_acumulador.sv
// Self-checking bench for mac_acumulador (N=25, F=15, M=5).
// Expected outputs come from an arithmetic model on longint values.
module tb_mac_acumulador;

  localparam int N = 25;
  localparam int F = 15;
  localparam int M = 5;
  localparam int W = 2*N;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mac_acumulador_if #(.N(N)) bus ();

  mac_acumulador #(.N(N), .F(F), .M(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     total = 0;
  int     bad   = 0;
  longint pv [M];

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: take the exact sum, round half-up to F fractional bits, then
  // clamp to the signed N-bit range.
  task automatic model(input longint sum, output longint ey, output logic eo);
    longint lim;
    longint r;
    lim = 64'sd1 <<< (N-1);
    r   = (sum + (64'sd1 <<< (F-1))) >>> F;
    if (r > lim - 64'sd1) begin
      ey = lim - 64'sd1;
      eo = 1'b1;
    end else if (r < -lim) begin
      ey = -lim;
      eo = 1'b1;
    end else begin
      ey = r;
      eo = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one full sample from start to the IDLE cycle after OUT, using the
  // products in pv[]. Before every product except the first, the bench
  // inserts a gap of gmin..gmax cycles. The gaps carry noise on prod and
  // random start pulses, and both must be ignored.
  task automatic run_sample(input string tag, input int gmin, input int gmax);
    longint sum;
    longint ey;
    logic   eo;
    int     g;
    sum = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, ".busy_acc"}, bus.busy, 1'b1);
    check({tag, ".ready_acc"}, bus.prod_ready, 1'b1);
    for (int i = 0; i < M; i++) begin
      g = (i == 0) ? 0 : int'($urandom_range(gmax, gmin));
      repeat (g) begin
        bus.prod_valid = 1'b0;
        bus.prod       = W'({$urandom(), $urandom()});
        bus.start      = 1'($urandom_range(1, 0));
        tick();
        bus.start      = 1'b0;
      end
      bus.prod       = W'(pv[i]);
      bus.prod_valid = 1'b1;
      tick();
      sum += pv[i];
      if (i < M-1) begin
        check({tag, ".yv_early"}, bus.y_valid, 1'b0);
      end
    end
    bus.prod_valid = 1'b0;
    model(sum, ey, eo);
    check({tag, ".yv"}, bus.y_valid, 1'b1);
    check({tag, ".y"}, bus.y, ey);
    check({tag, ".ovf"}, bus.ovf, eo);
    check({tag, ".ready_out"}, bus.prod_ready, 1'b0);
    check({tag, ".busy_out"}, bus.busy, 1'b1);
    bus.start = 1'($urandom_range(1, 0));   // start must be ignored in OUT
    tick();
    bus.start = 1'b0;
    check({tag, ".yv_pulse"}, bus.y_valid, 1'b0);
    check({tag, ".y_hold"}, bus.y, ey);
    check({tag, ".ovf_hold"}, bus.ovf, eo);
    check({tag, ".busy_idle"}, bus.busy, 1'b0);
    check({tag, ".ready_idle"}, bus.prod_ready, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".y"}, bus.y, 0);
    check({tag, ".yv"}, bus.y_valid, 1'b0);
    check({tag, ".ovf"}, bus.ovf, 1'b0);
    check({tag, ".ready"}, bus.prod_ready, 1'b0);
    check({tag, ".busy"}, bus.busy, 1'b0);
  endtask

  task automatic fill(input longint a, input longint rest);
    pv[0] = a;
    for (int i = 1; i < M; i++) pv[i] = rest;
  endtask

  initial begin
    logic signed [W-1:0] raw;

    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.prod       = '0;
    bus.prod_valid = 1'b0;
    #2;
    check_all_zero("rst0");
    reset = 1'b1;

    // Directed cases. They run back to back, so every start lands in the
    // single IDLE cycle that follows OUT.
    fill(64'sd1 <<< 30, 64'sd1 <<< 30);
    run_sample("pos", 0, 0);
    fill(-(64'sd1 <<< 30), -(64'sd1 <<< 30));
    run_sample("neg_gaps", 3, 3);
    fill(64'sd1 <<< 46, 64'sd1 <<< 46);
    run_sample("sat_pos", 0, 1);
    fill(-(64'sd1 <<< 46), -(64'sd1 <<< 46));
    run_sample("sat_neg", 0, 1);
    fill(64'sd1 <<< 14, 64'sd0);
    run_sample("rnd_pos", 0, 0);
    fill(-(64'sd1 <<< 14), 64'sd0);
    run_sample("rnd_neg", 0, 0);

    // Abort a sample with reset after three products, pulsing start while in ACC.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.prod       = W'(64'sd1 <<< 30);
      bus.prod_valid = 1'b1;
      bus.start      = 1'b1;
      tick();
    end
    bus.prod_valid = 1'b0;
    bus.start      = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    #3;
    reset = 1'b1;
    // Without a new start, products are ignored and no sample completes.
    for (int i = 0; i < M + 2; i++) begin
      bus.prod       = W'(64'sd1 <<< 30);
      bus.prod_valid = 1'b1;
      tick();
      check("norestart.yv", bus.y_valid, 1'b0);
      check("norestart.busy", bus.busy, 1'b0);
    end
    bus.prod_valid = 1'b0;
    fill(64'sd1 <<< 30, 64'sd1 <<< 30);
    run_sample("after_abort", 0, 2);

    // Random products at random magnitudes, with random gaps between them.
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < M; i++) begin
        raw   = W'({$urandom(), $urandom()});
        pv[i] = longint'(raw >>> $urandom_range(W-2, 0));
      end
      run_sample("rand", 0, 2);
      if ($urandom_range(1, 0) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
